pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/pc_ras.sv | 75 +++++++
 rtl/pc_gen.sv | 161 ++++++++++++++++
 tb/tb_pc_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the fetch-side PC generator.
//   pc_state_e    : PC generator FSM states (BOOT, RUN, HALT)
//   npc_sel_e     : next-PC source select, one value per candidate source
//   is_misaligned : true when a target address is not word aligned
package rv32i_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        NPC_HOLD     = 3'd0,
        NPC_SEQ      = 3'd1,
        NPC_RAS      = 3'd2,
        NPC_REDIRECT = 3'd3,
        NPC_TRAP     = 3'd4
    } npc_sel_e;

    // Only the two low address bits decide word alignment.
    function automatic logic is_misaligned(input logic [1:0] lsbs);
        return lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras
// Circular return-address stack.  A push when full overwrites the oldest
// entry, so the count saturates at DEPTH.  A simultaneous push and pop
// replaces the top entry in place and leaves the count unchanged.
// Ports:
//   clk_i     : clock, rising edge
//   rst_n     : asynchronous active-low reset (clears pointer and count)
//   push      : write push_data as the new top
//   pop       : discard the top entry (ignored when empty)
//   push_data : return address to push
//   top       : current top entry (undefined when empty)
//   empty     : no valid entries
module pc_ras
    import rv32i_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    // wr_ptr is the next free slot; the top entry sits just below it and
    // the pointer wraps naturally because DEPTH is a power of two.
    assign top_ptr = wr_ptr - PTR_W'(1);
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;

    // Storage carries no reset; the count alone says which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            if (do_pop) begin
                mem[top_ptr] <= push_data;
            end else begin
                mem[wr_ptr] <= push_data;
            end
        end
    end

    // Pointer and occupancy bookkeeping.  Push-and-pop together is a
    // replace, so neither pointer nor count moves.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push && do_pop) begin
            wr_ptr <= wr_ptr;
            count  <= count;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (do_pop) begin
            wr_ptr <= top_ptr;
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen
// Fetch program-counter generator with a BOOT/RUN/HALT control FSM.
// Next-PC priority: trap, redirect, RAS-predicted return, sequential.
// Misaligned trap/redirect targets are rejected: the PC holds and
// misalign_o pulses for one cycle.
// Optional feature: define PC_GEN_RAS_EN to build in the return address
// stack (pc_ras); without it call_i/ret_i are ignored.
// Ports:
//   clk_i, rst_n                    : clock, asynchronous active-low reset
//   fetch_ready_i                   : fetch accepts pc_o this cycle
//   redirect_valid_i, redirect_pc_i : execute-stage correction
//   trap_valid_i, trap_vec_i        : trap entry and handler address
//   halt_i, wake_i                  : WFI/halt request, interrupt wake-up
//   call_i, ret_i                   : predecode call/return marks
//   pc_o, pc_valid_o                : fetch PC and its valid flag
//   misalign_o                      : rejected misaligned target pulse
module pc_gen
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned     INC       = 4,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            wake_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

    pc_state_e       state_q;
    pc_state_e       state_d;
    npc_sel_e        npc_sel;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_seq;
    logic            misalign_q;
    logic            misalign_d;
    logic            handshake;
    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;

    assign pc_seq     = pc_q + INC_W;
    assign pc_valid_o = (state_q == RUN);
    assign handshake  = pc_valid_o && fetch_ready_i;
    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

`ifdef PC_GEN_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_pred;

    assign ras_top     = '0;
    assign ras_empty   = 1'b1;
    assign unused_pred = ^{call_i, ret_i, ras_push, ras_pop, RAS_DEPTH[0]};
`endif

    // Next-state and next-PC source.  A trap outranks everything and also
    // wakes a halted core; a halt request freezes the PC for that cycle.
    // Call/return prediction only acts on a plain handshake cycle.
    always_comb begin
        state_d    = state_q;
        npc_sel    = NPC_HOLD;
        misalign_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, HALT: begin
                if (trap_valid_i) begin
                    state_d = RUN;
                    if (is_misaligned(trap_vec_i[1:0])) begin
                        misalign_d = 1'b1;
                    end else begin
                        npc_sel = NPC_TRAP;
                    end
                end else begin
                    if (redirect_valid_i) begin
                        if (is_misaligned(redirect_pc_i[1:0])) begin
                            misalign_d = 1'b1;
                        end else begin
                            npc_sel = NPC_REDIRECT;
                        end
                    end
                    if (state_q == RUN && halt_i) begin
                        state_d = HALT;
                    end else if (state_q == HALT && wake_i) begin
                        state_d = RUN;
                    end else if (!redirect_valid_i && handshake) begin
                        npc_sel = NPC_SEQ;
`ifdef PC_GEN_RAS_EN
                        ras_push = call_i;
                        if (ret_i && !ras_empty) begin
                            ras_pop = 1'b1;
                            npc_sel = NPC_RAS;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // Next-PC multiplexer.
    always_comb begin
        pc_d = pc_q;
        case (npc_sel)
            NPC_TRAP:     pc_d = trap_vec_i;
            NPC_REDIRECT: pc_d = redirect_pc_i;
            NPC_RAS:      pc_d = ras_top;
            NPC_SEQ:      pc_d = pc_seq;
            default:      pc_d = pc_q;
        endcase
    end

    // State, PC and misalign flag registers; reset drops any pending
    // redirect and restarts from RESET_VEC through BOOT.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen
// Self-checking bench for pc_gen: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a behavioural model.  Honours PC_GEN_RAS_EN when defined.
module tb_pc_gen;

    localparam int unsigned     RAS_DEPTH = 4;
    localparam logic [31:0]     RV        = 32'h0000_0100;

    localparam int MODE_BOOT = 0;
    localparam int MODE_RUN  = 1;
    localparam int MODE_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic        halt;
    logic        wake;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic        pc_valid;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model state.
    int          m_mode = MODE_BOOT;
    logic [31:0] m_pc   = RV;
    bit          m_mis  = 1'b0;
    logic [31:0] m_ras[$];

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (RV),
        .INC       (4),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_n            (rst_n),
        .fetch_ready_i    (fetch_ready),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .trap_valid_i     (trap_valid),
        .trap_vec_i       (trap_vec),
        .halt_i           (halt),
        .wake_i           (wake),
        .call_i           (call),
        .ret_i            (ret),
        .pc_o             (pc),
        .pc_valid_o       (pc_valid),
        .misalign_o       (misalign)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Behavioural model: one step per rising edge, reset at any time.
    initial begin
        bit          hs;
        logic [31:0] npc;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = MODE_BOOT;
                m_pc   = RV;
                m_mis  = 1'b0;
                m_ras.delete();
            end else begin
                m_mis = 1'b0;
                hs    = (m_mode == MODE_RUN) && fetch_ready;
                if (m_mode == MODE_BOOT) begin
                    m_mode = MODE_RUN;
                end else if (trap_valid) begin
                    if (trap_vec[1:0] != 2'b00) m_mis = 1'b1;
                    else m_pc = trap_vec;
                    m_mode = MODE_RUN;
                end else begin
                    if (redirect_valid) begin
                        if (redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
                        else m_pc = redirect_pc;
                    end
                    if (m_mode == MODE_RUN && halt) begin
                        m_mode = MODE_HALT;
                    end else if (m_mode == MODE_HALT && wake) begin
                        m_mode = MODE_RUN;
                    end else if (!redirect_valid && hs) begin
                        npc = m_pc + 32'd4;
`ifdef PC_GEN_RAS_EN
                        if (ret && m_ras.size() > 0) begin
                            npc = m_ras[$];
                            void'(m_ras.pop_back());
                        end
                        if (call) begin
                            m_ras.push_back(m_pc + 32'd4);
                            if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                        end
`endif
                        m_pc = npc;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                n_checks++;
                if (pc !== m_pc || pc_valid !== (m_mode == MODE_RUN) || misalign !== m_mis) begin
                    n_fail++;
                    $display("[TB] FAIL model_cmp t=%0t: dut pc=%h valid=%b mis=%b, expected pc=%h valid=%b mis=%b",
                             $time, pc, pc_valid, misalign, m_pc, (m_mode == MODE_RUN), m_mis);
                end
            end
        end
    end

    // Drive one cycle of inputs, then return just after the capturing edge.
    task automatic applyStimulus(input bit rdy, input bit rv, input logic [31:0] rpc,
                                 input bit tv, input logic [31:0] tvec,
                                 input bit h, input bit w, input bit c, input bit r);
        fetch_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        trap_valid     = tv;
        trap_vec       = tvec;
        halt           = h;
        wake           = w;
        call           = c;
        ret            = r;
        @(posedge clk);
        #1;
    endtask

    // Literal check of the DUT outputs and of the model PC.
    task automatic checkOutput(input string name, input logic [31:0] exp_pc,
                               input bit exp_valid, input bit exp_mis);
        n_checks++;
        if (pc !== exp_pc || pc_valid !== exp_valid || misalign !== exp_mis) begin
            n_fail++;
            $display("[TB] FAIL %s: got pc=%h valid=%b mis=%b, expected pc=%h valid=%b mis=%b",
                     name, pc, pc_valid, misalign, exp_pc, exp_valid, exp_mis);
        end
        n_checks++;
        if (m_pc !== exp_pc) begin
            n_fail++;
            $display("[TB] FAIL %s_model: model pc=%h, expected %h", name, m_pc, exp_pc);
        end
    endtask

    function automatic logic [31:0] randTarget();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF4;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        else t[1:0] = 2'b00;
        return t;
    endfunction

    // Directed scenarios, then randomized traffic.
    initial begin
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        checkOutput("reset_state", RV, 0, 0);

        rst_n = 1'b1;
        checkOutput("boot_cycle", RV, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("first_pc", 32'h100, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("seq_104", 32'h104, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("seq_108", 32'h108, 1, 0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("stall_hold", 32'h108, 1, 0);
        end
        applyStimulus(0, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_redirect", 32'h2000, 1, 0);

        applyStimulus(1, 1, 32'h2000, 1, 32'h80, 0, 0, 0, 0);
        checkOutput("trap_over_redirect", 32'h80, 1, 0);
        applyStimulus(1, 1, 32'h2002, 0, 0, 0, 0, 0, 0);
        checkOutput("misalign_pulse", 32'h80, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("misalign_clear", 32'h80, 1, 0);

        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("halt_enter", 32'h80, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("halt_hold", 32'h80, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("wake", 32'h80, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("after_wake", 32'h84, 1, 0);

        applyStimulus(0, 1, 32'h10, 0, 0, 0, 0, 0, 0);
        checkOutput("goto_10", 32'h10, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("call_at_10", 32'h14, 1, 0);
        applyStimulus(0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
        checkOutput("goto_40", 32'h40, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("call_at_40", 32'h44, 1, 0);
`ifdef PC_GEN_RAS_EN
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_1", 32'h44, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_2", 32'h14, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_empty", 32'h18, 1, 0);
`else
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_ignored_1", 32'h48, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_ignored_2", 32'h4C, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_ignored_3", 32'h50, 1, 0);
`endif

        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        checkOutput("goto_top", 32'hFFFF_FFFC, 1, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap_zero", 32'h0, 1, 0);

        fetch_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", RV, 0, 0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        checkOutput("reset_boot", RV, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_first_pc", RV, 1, 0);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            applyStimulus(($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 9) == 0), randTarget(),
                          ($urandom_range(0, 31) == 0), randTarget(),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 5) == 0));
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
